// File: rtl/noc_pkg.sv
// Shared mesh-NoC definitions.
//   - Router port indices (NORTH..LOCAL) and NUM_PORTS.
//   - Address pack/unpack helpers. The X/Y/address widths are passed as arguments.
//     Values travel in a 32-bit container, so every address width must be <= 32.
//     The X field sits in the top X bits of the address.
//     The Y field sits directly below the X field.
//     Any remaining low bits are zero.
package noc_pkg;

  localparam int NORTH     = 0;
  localparam int EAST      = 1;
  localparam int SOUTH     = 2;
  localparam int WEST      = 3;
  localparam int LOCAL     = 4;
  localparam int NUM_PORTS = 5;

  function automatic logic [31:0] noc_field_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Build a router address from (x,y); low fill bits are zero.
  function automatic logic [31:0] noc_pack_addr(input logic [31:0] x, input logic [31:0] y,
                                                input int addr_w, input int x_w, input int y_w);
    logic [31:0] xm;
    logic [31:0] ym;
    xm = x & noc_field_mask(x_w);
    ym = y & noc_field_mask(y_w);
    return (xm << (addr_w - x_w)) | (ym << (addr_w - x_w - y_w));
  endfunction

  // Extract the X field of an address (zero-extended).
  function automatic logic [31:0] noc_addr_x(input logic [31:0] addr, input int addr_w,
                                             input int x_w);
    return (addr >> (addr_w - x_w)) & noc_field_mask(x_w);
  endfunction

  // Extract the Y field of an address (zero-extended).
  function automatic logic [31:0] noc_addr_y(input logic [31:0] addr, input int addr_w,
                                             input int x_w, input int y_w);
    return (addr >> (addr_w - x_w - y_w)) & noc_field_mask(y_w);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read.
// Ports:
//   - clk, rst: clock and synchronous active-high reset. Reset empties the FIFO.
//   - push, push_data: write request and write data. A push is ignored while full.
//   - pop, pop_data: read request and the data at the head.
//     pop_data is 0 when the FIFO is empty. A pop is ignored while empty.
//   - full, empty, count: occupancy. count is clog2(DEPTH)+1 bits wide.
// Constraint: DEPTH must be a power of 2 and >= 2, so the pointers wrap by overflow.
module noc_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Fullness is judged on the current count only.
  // A pop in the same cycle therefore never makes room for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The storage array is not reset.
  // Stale contents are never visible, because reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/mesh_network_interface.sv
// Network interface between a core and the LOCAL port of a mesh router.
// Ports:
//   - clk, rst: clock and synchronous active-high reset.
//   - local_x_addr, local_y_addr: this tile's coordinates.
//   - Injection from the core: tx_valid, tx_data, tx_dest_x, tx_dest_y, tx_ready.
//   - To the router local input: noc_valid_o, noc_data_o, noc_addr_o, noc_ready_i.
//   - From the router local output: noc_valid_i, noc_data_i, noc_addr_i, noc_ready_o.
//   - Ejection to the core: rx_valid, rx_data, rx_src_addr, rx_ready.
//   - Statistics:
//       stat_clr clears all statistics.
//       tx_flit_cnt and rx_flit_cnt wrap.
//       drop_cnt saturates.
//       misroute_err is a sticky misroute flag.
// Behaviour:
//   - Flits are buffered in a TX FIFO and an RX FIFO; there is no bypass path.
//   - A flit from the router whose X/Y does not match this tile is dropped, not delivered.
//   - ADDR_WIDTH must be <= 32.
module mesh_network_interface
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [X_ADDR_WIDTH-1:0] local_x_addr,
  input  logic [Y_ADDR_WIDTH-1:0] local_y_addr,
  input  logic                    tx_valid,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic [X_ADDR_WIDTH-1:0] tx_dest_x,
  input  logic [Y_ADDR_WIDTH-1:0] tx_dest_y,
  output logic                    tx_ready,
  output logic                    noc_valid_o,
  output logic [DATA_WIDTH-1:0]   noc_data_o,
  output logic [ADDR_WIDTH-1:0]   noc_addr_o,
  input  logic                    noc_ready_i,
  input  logic                    noc_valid_i,
  input  logic [DATA_WIDTH-1:0]   noc_data_i,
  input  logic [ADDR_WIDTH-1:0]   noc_addr_i,
  output logic                    noc_ready_o,
  output logic                    rx_valid,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic [ADDR_WIDTH-1:0]   rx_src_addr,
  input  logic                    rx_ready,
  input  logic                    stat_clr,
  output logic [CNT_WIDTH-1:0]    tx_flit_cnt,
  output logic [CNT_WIDTH-1:0]    rx_flit_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic                    misroute_err
);

  localparam int FLIT_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0]        tx_addr;
  logic [FLIT_W-1:0]            tx_dout;
  logic [FLIT_W-1:0]            rx_dout;
  logic                         tx_full;
  logic                         tx_empty;
  logic                         rx_full;
  logic                         rx_empty;
  logic [$clog2(TX_DEPTH):0]    tx_count;
  logic [$clog2(RX_DEPTH):0]    rx_count;
  logic                         addr_match;
  logic                         rx_accept;
  logic                         rx_push;
  logic                         rx_drop;
  logic                         tx_fire;
  logic                         rx_fire;
  logic [CNT_WIDTH-1:0]         tx_flit_cnt_reg;
  logic [CNT_WIDTH-1:0]         rx_flit_cnt_reg;
  logic [CNT_WIDTH-1:0]         drop_cnt_reg;
  logic                         misroute_err_reg;
  logic                         unused_fifo_count;

  // All handshake outputs are forced low while reset is held.
  // This holds even in the cycle before the reset edge empties the FIFOs.
  assign tx_ready    = !rst && !tx_full;
  assign noc_valid_o = !rst && !tx_empty;
  assign noc_ready_o = !rst && !rx_full;
  assign rx_valid    = !rst && !rx_empty;

  assign tx_addr = ADDR_WIDTH'(noc_pack_addr(32'(tx_dest_x), 32'(tx_dest_y),
                                             ADDR_WIDTH, X_ADDR_WIDTH, Y_ADDR_WIDTH));

  assign noc_addr_o = tx_dout[FLIT_W-1 -: ADDR_WIDTH];
  assign noc_data_o = tx_dout[DATA_WIDTH-1:0];

  noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid && tx_ready),
    .push_data ({tx_addr, tx_data}),
    .pop       (tx_fire),
    .pop_data  (tx_dout),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // Readiness toward the router depends only on RX fullness.
  // Address contents never affect it; the X/Y check only decides keep-or-drop.
  assign addr_match =
    (noc_addr_x(32'(noc_addr_i), ADDR_WIDTH, X_ADDR_WIDTH) == 32'(local_x_addr)) &&
    (noc_addr_y(32'(noc_addr_i), ADDR_WIDTH, X_ADDR_WIDTH, Y_ADDR_WIDTH) == 32'(local_y_addr));
  assign rx_accept = noc_valid_i && noc_ready_o;
  assign rx_push   = rx_accept && addr_match;
  assign rx_drop   = rx_accept && !addr_match;

  noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data ({noc_addr_i, noc_data_i}),
    .pop       (rx_fire),
    .pop_data  (rx_dout),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign rx_src_addr = rx_dout[FLIT_W-1 -: ADDR_WIDTH];
  assign rx_data     = rx_dout[DATA_WIDTH-1:0];

  // FIFO occupancy is not needed here; full/empty carry all the flow control.
  assign unused_fifo_count = ^{tx_count, rx_count};

  assign tx_fire = noc_valid_o && noc_ready_i;
  assign rx_fire = rx_valid && rx_ready;

  // stat_clr takes priority over any increment or misroute in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      tx_flit_cnt_reg  <= '0;
      rx_flit_cnt_reg  <= '0;
      drop_cnt_reg     <= '0;
      misroute_err_reg <= 1'b0;
    end else begin
      if (tx_fire) tx_flit_cnt_reg <= tx_flit_cnt_reg + CNT_WIDTH'(1);
      if (rx_fire) rx_flit_cnt_reg <= rx_flit_cnt_reg + CNT_WIDTH'(1);
      if (rx_drop) begin
        misroute_err_reg <= 1'b1;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign tx_flit_cnt  = tx_flit_cnt_reg;
  assign rx_flit_cnt  = rx_flit_cnt_reg;
  assign drop_cnt     = drop_cnt_reg;
  assign misroute_err = misroute_err_reg;

endmodule

// File: tb/tb_mesh_network_interface.sv
module tb_mesh_network_interface;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int TXD  = 4;
  localparam int RXD  = 4;
  localparam int CW   = 4;                 // narrow counters so wrap/saturation are reachable
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [XW-1:0] local_x_addr;
  logic [YW-1:0] local_y_addr;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [XW-1:0] tx_dest_x;
  logic [YW-1:0] tx_dest_y;
  logic          tx_ready;
  logic          noc_valid_o;
  logic [DW-1:0] noc_data_o;
  logic [AW-1:0] noc_addr_o;
  logic          noc_ready_i;
  logic          noc_valid_i;
  logic [DW-1:0] noc_data_i;
  logic [AW-1:0] noc_addr_i;
  logic          noc_ready_o;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic [AW-1:0] rx_src_addr;
  logic          rx_ready;
  logic          stat_clr;
  logic [CW-1:0] tx_flit_cnt;
  logic [CW-1:0] rx_flit_cnt;
  logic [CW-1:0] drop_cnt;
  logic          misroute_err;

  mesh_network_interface #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW),
    .TX_DEPTH(TXD), .RX_DEPTH(RXD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .local_x_addr(local_x_addr), .local_y_addr(local_y_addr),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y),
    .tx_ready(tx_ready), .noc_valid_o(noc_valid_o), .noc_data_o(noc_data_o),
    .noc_addr_o(noc_addr_o), .noc_ready_i(noc_ready_i), .noc_valid_i(noc_valid_i),
    .noc_data_i(noc_data_i), .noc_addr_i(noc_addr_i), .noc_ready_o(noc_ready_o),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_src_addr(rx_src_addr), .rx_ready(rx_ready),
    .stat_clr(stat_clr), .tx_flit_cnt(tx_flit_cnt), .rx_flit_cnt(rx_flit_cnt),
    .drop_cnt(drop_cnt), .misroute_err(misroute_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: two flit queues plus plain integer statistics.
  logic [AW+DW-1:0] txq[$];
  logic [AW+DW-1:0] rxq[$];
  int m_tx_cnt, m_rx_cnt, m_drop;
  bit m_err;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] data;
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] ej_addr;
    bit            exp_rx;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_pack(input logic [XW-1:0] x, input logic [YW-1:0] y);
    int v;
    v = (int'(x) << (AW - XW)) | (int'(y) << (AW - XW - YW));
    return v[AW-1:0];
  endfunction

  function automatic bit is_local(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    return ((ai >> (AW - XW)) == int'(local_x_addr)) &&
           (((ai >> (AW - XW - YW)) & ((1 << YW) - 1)) == int'(local_y_addr));
  endfunction

  // Predict the effect of the currently driven inputs at the next edge.
  // Then advance one clock and compare every output against the model.
  task automatic cycle();
    bit tx_push, tx_pop, rx_acc, rx_pop;
    logic [AW+DW-1:0] tf, rf;
    if (rst) begin
      txq.delete();
      rxq.delete();
      m_tx_cnt = 0; m_rx_cnt = 0; m_drop = 0; m_err = 0;
    end else begin
      tx_push = tx_valid && (txq.size() < TXD);
      tx_pop  = noc_ready_i && (txq.size() > 0);
      rx_acc  = noc_valid_i && (rxq.size() < RXD);
      rx_pop  = rx_ready && (rxq.size() > 0);
      if (tx_pop) begin
        $display("tx flit to router addr=%h data=%h", txq[0][AW+DW-1:DW], txq[0][DW-1:0]);
        void'(txq.pop_front());
        m_tx_cnt = (m_tx_cnt + 1) & CMAX;
      end
      if (tx_push) txq.push_back({exp_pack(tx_dest_x, tx_dest_y), tx_data});
      if (rx_pop) begin
        $display("rx flit to core addr=%h data=%h", rxq[0][AW+DW-1:DW], rxq[0][DW-1:0]);
        void'(rxq.pop_front());
        m_rx_cnt = (m_rx_cnt + 1) & CMAX;
      end
      if (rx_acc) begin
        if (is_local(noc_addr_i)) rxq.push_back({noc_addr_i, noc_data_i});
        else begin
          $display("misrouted flit dropped addr=%h", noc_addr_i);
          if (m_drop < CMAX) m_drop++;
          m_err = 1;
        end
      end
      if (stat_clr) begin
        m_tx_cnt = 0; m_rx_cnt = 0; m_drop = 0; m_err = 0;
      end
    end
    @(posedge clk);
    #1;
    tf = (txq.size() > 0) ? txq[0] : '0;
    rf = (rxq.size() > 0) ? rxq[0] : '0;
    chk("m_tx_ready",    tx_ready,     !rst && (txq.size() < TXD));
    chk("m_noc_valid_o", noc_valid_o,  !rst && (txq.size() > 0));
    chk("m_noc_addr_o",  noc_addr_o,   tf[AW+DW-1:DW]);
    chk("m_noc_data_o",  noc_data_o,   tf[DW-1:0]);
    chk("m_noc_ready_o", noc_ready_o,  !rst && (rxq.size() < RXD));
    chk("m_rx_valid",    rx_valid,     !rst && (rxq.size() > 0));
    chk("m_rx_src_addr", rx_src_addr,  rf[AW+DW-1:DW]);
    chk("m_rx_data",     rx_data,      rf[DW-1:0]);
    chk("m_tx_flit_cnt", tx_flit_cnt,  m_tx_cnt);
    chk("m_rx_flit_cnt", rx_flit_cnt,  m_rx_cnt);
    chk("m_drop_cnt",    drop_cnt,     m_drop);
    chk("m_misroute",    misroute_err, m_err);
  endtask

  initial begin
    // Table: injection packing plus the ejection-side check, with the tile at (2,1).
    vt[0] = '{x:4'h3, y:4'h1, data:32'h1111_1111, exp_addr:8'h31, ej_addr:8'h21, exp_rx:1'b1};
    vt[1] = '{x:4'h2, y:4'h1, data:32'h2222_2222, exp_addr:8'h21, ej_addr:8'h55, exp_rx:1'b0};
    vt[2] = '{x:4'h0, y:4'h0, data:32'h3333_3333, exp_addr:8'h00, ej_addr:8'h20, exp_rx:1'b0};
    vt[3] = '{x:4'hF, y:4'hF, data:32'h4444_4444, exp_addr:8'hFF, ej_addr:8'h11, exp_rx:1'b0};
    vt[4] = '{x:4'hA, y:4'h5, data:32'h5555_5555, exp_addr:8'hA5, ej_addr:8'h21, exp_rx:1'b1};
    vt[5] = '{x:4'h1, y:4'hE, data:32'h6666_6666, exp_addr:8'h1E, ej_addr:8'h22, exp_rx:1'b0};

    m_tx_cnt = 0; m_rx_cnt = 0; m_drop = 0; m_err = 0;
    local_x_addr = 4'h2; local_y_addr = 4'h1;
    rst = 1'b1; stat_clr = 1'b0;
    noc_ready_i = 1'b0; noc_valid_i = 1'b0; noc_data_i = '0; noc_addr_i = '0; rx_ready = 1'b0;
    tx_valid = 1'b1; tx_data = 32'hA5A5_0001; tx_dest_x = 4'h3; tx_dest_y = 4'h1;

    // Reset and basic injection.
    cycle();
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_noc_valid", noc_valid_o, 1'b0);
    cycle();
    chk("rst_tx_ready2", tx_ready, 1'b0);
    rst = 1'b0;
    cycle();
    chk("inj_valid", noc_valid_o, 1'b1);
    chk("inj_addr", noc_addr_o, 8'h31);
    chk("inj_data", noc_data_o, 32'hA5A5_0001);
    chk("inj_cnt_before", tx_flit_cnt, 0);
    tx_valid = 1'b0; noc_ready_i = 1'b1;
    cycle();
    chk("inj_cnt_after", tx_flit_cnt, 1);
    $display("basic injection done tx_flit_cnt=%0d", tx_flit_cnt);

    // TX backpressure: four flits fill the FIFO, the fifth waits for space.
    noc_ready_i = 1'b0; tx_valid = 1'b1; tx_dest_x = 4'h1; tx_dest_y = 4'h2;
    for (int i = 0; i < 4; i++) begin
      tx_data = 32'd100 + 32'(i);
      cycle();
    end
    chk("bp_full_ready", tx_ready, 1'b0);
    tx_data = 32'd104;
    noc_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) tx_valid = 1'b0;
      chk("bp_order", noc_data_o, 32'd100 + 32'(k));
      cycle();
    end
    chk("bp_drained", noc_valid_o, 1'b0);
    $display("backpressure sequence done");

    // Ejection of a local flit held by the core for three cycles.
    rx_ready = 1'b0; noc_valid_i = 1'b1; noc_addr_i = 8'h21; noc_data_i = 32'h1234;
    cycle();
    noc_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ej_hold_valid", rx_valid, 1'b1);
      chk("ej_hold_data", rx_data, 32'h1234);
      cycle();
    end
    rx_ready = 1'b1;
    cycle();
    chk("ej_rx_cnt", rx_flit_cnt, 1);
    chk("ej_empty", rx_valid, 1'b0);
    $display("ejection sequence done rx_flit_cnt=%0d", rx_flit_cnt);

    // Misroute, then clear; then a misroute that coincides with a clear.
    noc_valid_i = 1'b1; noc_addr_i = 8'h55; noc_data_i = 32'hDEAD;
    cycle();
    noc_valid_i = 1'b0;
    chk("mis_no_rx", rx_valid, 1'b0);
    chk("mis_flag", misroute_err, 1'b1);
    chk("mis_drop", drop_cnt, 1);
    stat_clr = 1'b1;
    cycle();
    chk("clr_tx", tx_flit_cnt, 0);
    chk("clr_rx", rx_flit_cnt, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_flag", misroute_err, 1'b0);
    noc_valid_i = 1'b1;
    cycle();
    chk("clr_wins_flag", misroute_err, 1'b0);
    chk("clr_wins_drop", drop_cnt, 0);
    stat_clr = 1'b0;
    for (int k = 0; k < CMAX + 2; k++) cycle();
    chk("drop_saturate", drop_cnt, CMAX);
    noc_valid_i = 1'b0;
    $display("misroute sequence done drop_cnt=%0d", drop_cnt);

    // RX full: a pop in the same cycle does not admit a push.
    rx_ready = 1'b0; noc_valid_i = 1'b1; noc_addr_i = 8'h21;
    for (int i = 0; i < 4; i++) begin
      noc_data_i = 32'h200 + 32'(i);
      cycle();
    end
    chk("rxfull_ready", noc_ready_o, 1'b0);
    rx_ready = 1'b1; noc_data_i = 32'h2FF;
    cycle();
    noc_valid_i = 1'b0;
    chk("rxfull_cnt3_ready", noc_ready_o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("rxfull_order", rx_data, 32'h201 + 32'(k));
      cycle();
    end
    chk("rxfull_no_extra", rx_valid, 1'b0);
    $display("rx full sequence done");

    // Reset mid-traffic with three flits buffered.
    noc_ready_i = 1'b0; tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 32'h300 + 32'(i);
      cycle();
    end
    tx_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_valid", noc_valid_o, 1'b0);
    noc_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("midrst_no_stale", noc_valid_o, 1'b0);
      chk("midrst_cnt", tx_flit_cnt, 0);
    end
    $display("mid-traffic reset sequence done");

    // Table-driven vectors.
    noc_ready_i = 1'b1; rx_ready = 1'b1;
    foreach (vt[i]) begin
      tx_valid = 1'b1; tx_data = vt[i].data; tx_dest_x = vt[i].x; tx_dest_y = vt[i].y;
      cycle();
      tx_valid = 1'b0;
      chk("vec_valid", noc_valid_o, 1'b1);
      chk("vec_addr", noc_addr_o, vt[i].exp_addr);
      chk("vec_data", noc_data_o, vt[i].data);
      noc_valid_i = 1'b1; noc_addr_i = vt[i].ej_addr; noc_data_i = vt[i].data;
      cycle();
      noc_valid_i = 1'b0;
      chk("vec_rx", rx_valid, vt[i].exp_rx);
      $display("vector %0d dest=(%0d,%0d) addr=%h eject=%h rx=%0d",
               i, vt[i].x, vt[i].y, noc_addr_o, vt[i].ej_addr, rx_valid);
      cycle();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      tx_valid    = 1'($urandom_range(0, 1));
      tx_data     = $urandom;
      tx_dest_x   = 4'($urandom);
      tx_dest_y   = 4'($urandom);
      noc_ready_i = ($urandom_range(0, 3) != 0);
      noc_valid_i = 1'($urandom_range(0, 1));
      noc_addr_i  = ($urandom_range(0, 1) == 1) ? 8'h21 : 8'($urandom);
      noc_data_i  = $urandom;
      rx_ready    = ($urandom_range(0, 3) != 0);
      stat_clr    = ($urandom_range(0, 31) == 0);
      cycle();
    end

    tx_valid = 1'b0; noc_valid_i = 1'b0; stat_clr = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
